// File: rtl/packet_buffer_pkg.sv
// Shared packet buffer types: header layout, read FSM states and
// beat-count helper used by both the read and write controllers.
package packet_buffer_pkg;

    // packet_length occupies the least significant 16 bits of the header beat
    typedef struct packed {
        logic [47:0] rsvd;
        logic [15:0] packet_length;
    } packet_header_t;

    localparam int unsigned HDR_BITS = $bits(packet_header_t);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BODY
    } rd_state_t;

    // ceil(len / beat_bytes); beat_bytes is a power-of-two constant at use sites
    function automatic logic [16:0] beats_from_length(
        input logic [15:0] len,
        input int unsigned beat_bytes
    );
        return 17'((32'(len) + beat_bytes - 32'd1) / beat_bytes);
    endfunction

    function automatic logic [15:0] header_length(input packet_header_t hdr);
        return hdr.packet_length;
    endfunction

endpackage

// File: rtl/packet_buffer_read_controller_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping.
// Ports: req_i request vector, ptr_i start index, grant_o index, any_valid_o.
module rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [IDX_W-1:0]     grant_o,
    output logic                 any_valid_o
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_o     = '0;
        any_valid_o = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr_i) + i) % NUM_LANES;
            if (req_i[IDX_W'(j)]) begin
                grant_o     = IDX_W'(j);
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_buffer_read_controller.sv
// Drains NUM_LANES lane FIFOs one whole packet at a time, round-robin.
// Ports: lane_valid_i/lane_data_i/lane_ready_o per lane; registered output
// stream out_valid_o/out_data_o/out_last_o/out_lane_o with out_ready_i;
// len_err_o pulses for a zero or oversized header length.
module packet_buffer_read_controller
    import packet_buffer_pkg::*;
#(
    parameter int NUM_LANES             = 4,
    parameter int HEADER_WIDTH          = 64,
    parameter int AXI_WIDTH             = 64,
    parameter int MAX_PACKET_LENGTH     = 1536,
    parameter int LANE_SELECT_IDX_WIDTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             lane_valid_i [NUM_LANES-1:0],
    input  logic [AXI_WIDTH-1:0]             lane_data_i  [NUM_LANES-1:0],
    output logic                             lane_ready_o [NUM_LANES-1:0],
    output logic                             out_valid_o,
    output logic [AXI_WIDTH-1:0]             out_data_o,
    output logic                             out_last_o,
    output logic [LANE_SELECT_IDX_WIDTH-1:0] out_lane_o,
    input  logic                             out_ready_i,
    output logic                             len_err_o
);

    localparam int unsigned BEAT_BYTES = AXI_WIDTH / 8;
    localparam int unsigned MAX_BEATS  =
        (MAX_PACKET_LENGTH + BEAT_BYTES - 1) / BEAT_BYTES;
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam int IDX_W = LANE_SELECT_IDX_WIDTH;

    if ((BEAT_BYTES & (BEAT_BYTES - 1)) != 0) begin : g_bad_beat
        $error("AXI_WIDTH/8 must be a power of two");
    end
    if (HEADER_WIDTH != HDR_BITS || AXI_WIDTH < HEADER_WIDTH) begin : g_bad_hdr
        $error("header width does not fit the beat");
    end

    rd_state_t            state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     remain_q, remain_d;
    logic                 out_valid_q, out_valid_d;
    logic [AXI_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [IDX_W-1:0]     out_lane_q, out_lane_d;
    logic                 len_err_q, len_err_d;

    logic [NUM_LANES-1:0] req;
    logic [IDX_W-1:0]     arb_grant;
    logic                 arb_any;
    logic                 can_load;
    logic                 xfer;
    logic [15:0]          hdr_len;
    logic [16:0]          hdr_beats;
    logic [16:0]          beats_eff;
    logic                 len_zero;
    logic                 len_over;
    logic [IDX_W-1:0]     next_ptr;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            req[i] = lane_valid_i[i];
        end
    end

    rr_arbiter #(
        .NUM_LANES(NUM_LANES),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req_i      (req),
        .ptr_i      (rr_ptr_q),
        .grant_o    (arb_grant),
        .any_valid_o(arb_any)
    );

    assign can_load = !out_valid_q || out_ready_i;
    assign xfer     = (state_q != IDLE) && lane_valid_i[grant_q] && can_load;

    always_comb begin
        for (int g = 0; g < NUM_LANES; g++) begin
            lane_ready_o[g] = (state_q != IDLE) &&
                              (grant_q == IDX_W'(g)) && can_load;
        end
    end

    assign hdr_len = header_length(
        packet_header_t'(lane_data_i[grant_q][HEADER_WIDTH-1:0]));
    assign hdr_beats = beats_from_length(hdr_len, BEAT_BYTES);
    assign len_zero  = (hdr_len == 16'd0);
    assign len_over  = (hdr_beats > 17'(MAX_BEATS));
    // Zero length still carries its header beat; oversize is truncated.
    assign beats_eff = len_zero ? 17'd1 :
                       len_over ? 17'(MAX_BEATS) : hdr_beats;
    // With one lane the modulo folds the pointer to 0.
    assign next_ptr  = IDX_W'((32'(grant_q) + 32'd1) % NUM_LANES);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        remain_d    = remain_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_lane_d  = out_lane_q;
        len_err_d   = 1'b0;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_data_i[grant_q];
            out_lane_d  = grant_q;
            out_last_d  = 1'b0;
        end else if (can_load) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    len_err_d = len_zero || len_over;
                    if (beats_eff == 17'd1) begin
                        out_last_d = 1'b1;
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                    end else begin
                        remain_d = CNT_W'(beats_eff - 17'd1);
                        state_d  = BODY;
                    end
                end
            end
            BODY: begin
                if (xfer) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == CNT_W'(1)) begin
                        out_last_d = 1'b1;
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            remain_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_lane_q  <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            remain_q    <= remain_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_lane_q  <= out_lane_d;
            len_err_q   <= len_err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_lane_o  = out_lane_q;
    assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_packet_buffer_read_controller.sv
// Scoreboard bench for packet_buffer_read_controller: lane FIFO models,
// a packet-level round-robin reference model and an output monitor.
module tb_packet_buffer_read_controller;

    localparam int NL = 4;
    localparam int W  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          lane_valid [NL-1:0];
    logic [W-1:0]  lane_data  [NL-1:0];
    logic          lane_ready [NL-1:0];
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [1:0]    out_lane;
    logic          out_ready;
    logic          len_err;

    packet_buffer_read_controller dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .lane_valid_i(lane_valid),
        .lane_data_i (lane_data),
        .lane_ready_o(lane_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_lane_o  (out_lane),
        .out_ready_i (out_ready),
        .len_err_o   (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          last;
        int          lane;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] lane_q   [NL][$];
    bit          lane_hdr [NL][$];
    int          plen     [NL][$];
    int          m_ptr;
    int          tests;
    int          fails;
    int          rdy_mode;
    bit          stall_en;
    int          cyc;
    bit          in_rst;
    int          n_acc;
    int          first_acc;
    int          last_acc;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level reference: beats per packet and error from the length rule.
    task automatic emit(input int l, input int len);
        int  nb;
        bit  err;
        logic [63:0] d;
        nb  = (len == 0) ? 1 : (len + 7) / 8;
        if (nb > 192) nb = 192;
        err = (len == 0) || (len > 1536);
        for (int k = 0; k < nb; k++) begin
            if (k == 0) d = {$urandom, 16'($urandom), 16'(len)};
            else        d = {$urandom, $urandom};
            lane_q[l].push_back(d);
            lane_hdr[l].push_back(k == 0);
            sb.push_back('{d, (k == nb - 1), l, (k == 0) && err});
        end
    endtask

    // Round-robin over lanes holding whole packets, pointer past last winner.
    task automatic build();
        bit found;
        int l;
        forever begin
            found = 0;
            for (int i = 0; i < NL; i++) begin
                l = (m_ptr + i) % NL;
                if (!found && plen[l].size() > 0) begin
                    emit(l, plen[l].pop_front());
                    m_ptr = (l + 1) % NL;
                    found = 1;
                end
            end
            if (!found) break;
        end
    endtask

    function automatic bit lanes_busy();
        for (int l = 0; l < NL; l++)
            if (lane_q[l].size() > 0) return 1;
        return 0;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() > 0 || lanes_busy() || out_valid) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(n < budget, "drain_timeout", n, budget);
        repeat (2) @(posedge clk);
    endtask

    function automatic int rand_len();
        case ($urandom % 8)
            0:       return 0;
            1:       return 1536;
            2:       return 1537 + int'($urandom % 600);
            3:       return 8 * (int'($urandom % 4) + 1);
            default: return 1 + int'($urandom % 200);
        endcase
    endfunction

    // Lane FIFO models and out_ready driver
    initial begin
        bit pop_p [NL];
        for (int l = 0; l < NL; l++) begin
            lane_valid[l] = 1'b0;
            lane_data[l]  = '0;
        end
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            for (int l = 0; l < NL; l++)
                pop_p[l] = lane_valid[l] && lane_ready[l];
            @(posedge clk);
            #1;
            cyc++;
            for (int l = 0; l < NL; l++) begin
                if (pop_p[l] && lane_q[l].size() > 0) begin
                    void'(lane_q[l].pop_front());
                    void'(lane_hdr[l].pop_front());
                end
            end
            case (rdy_mode)
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       out_ready = ($urandom % 10) < 7;
                default: out_ready = 1'b1;
            endcase
            for (int l = 0; l < NL; l++) begin
                if (lane_q[l].size() > 0) begin
                    lane_data[l]  = lane_q[l][0];
                    lane_valid[l] = !(stall_en && !lane_hdr[l][0] &&
                                      ($urandom % 3 == 0));
                end else begin
                    lane_valid[l] = 1'b0;
                    lane_data[l]  = '0;
                end
            end
        end
    end

    // Output monitor
    initial begin
        bit          pv, pr, pl, fresh, err_obs;
        logic [63:0] pd;
        logic [1:0]  pln;
        int          ones;
        exp_t        e;
        pv = 0; pr = 0; pl = 0; pd = '0; pln = '0; err_obs = 0;
        forever begin
            @(negedge clk);
            if (rst || in_rst) begin
                pv = 0;
                pr = 0;
                continue;
            end
            ones = 0;
            for (int l = 0; l < NL; l++) ones += int'(lane_ready[l]);
            chk(ones <= 1, "ready_onehot", ones, 1);
            if (out_valid && !out_ready)
                chk(ones == 0, "ready_in_stall", ones, 0);
            if (pv && !pr)
                chk(out_valid && out_data == pd && out_last == pl &&
                    out_lane == pln, "hold_stable", out_data, pd);
            fresh = out_valid && !(pv && !pr);
            if (fresh) err_obs = len_err;
            else if (len_err) chk(0, "len_err_pulse", 1, 0);
            if (out_valid && out_ready) begin
                n_acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (sb.size() == 0) begin
                    chk(0, "unexpected_beat", out_data, 0);
                end else begin
                    e = sb.pop_front();
                    chk(out_data == e.data, "data", out_data, e.data);
                    chk(out_last == e.last, "last", out_last, e.last);
                    chk(out_lane == 2'(e.lane), "lane", out_lane, e.lane);
                    chk(err_obs == e.err, "len_err", err_obs, e.err);
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            pl = out_last;  pln = out_lane;
        end
    end

    initial begin
        int ones;
        int base;
        int n;
        rst = 1'b1; in_rst = 1'b1; rdy_mode = 0; stall_en = 0;
        m_ptr = 0; first_acc = -1; tests = 0; fails = 0;
        repeat (3) @(posedge clk);
        #1;
        ones = 0;
        for (int l = 0; l < NL; l++) ones += int'(lane_ready[l]);
        chk(out_valid == 0, "rst_valid", out_valid, 0);
        chk(out_last == 0, "rst_last", out_last, 0);
        chk(len_err == 0, "rst_len_err", len_err, 0);
        chk(out_lane == 0, "rst_lane", out_lane, 0);
        chk(ones == 0, "rst_ready", ones, 0);
        @(negedge clk);
        rst = 1'b0; in_rst = 1'b0;
        @(posedge clk);

        plen[0].push_back(8);
        build(); drain(200);

        plen[2].push_back(20);
        build(); drain(200);

        plen[1].push_back(16);
        plen[3].push_back(9);
        first_acc = -1; n_acc = 0;
        build(); drain(200);
        chk(n_acc == 4, "rr_beats", n_acc, 4);
        chk(last_acc - first_acc + 1 == 5, "throughput",
            last_acc - first_acc + 1, 5);

        plen[1].push_back(8);
        plen[0].push_back(8);
        build(); drain(200);

        rdy_mode = 1;
        plen[1].push_back(32);
        build(); drain(200);
        rdy_mode = 0;

        plen[3].push_back(0);
        plen[0].push_back(2000);
        build(); drain(1000);

        rdy_mode = 2; stall_en = 1;
        for (int r = 0; r < 25; r++) begin
            for (int l = 0; l < NL; l++)
                repeat ($urandom % 3) plen[l].push_back(rand_len());
            build(); drain(20000);
        end
        rdy_mode = 0; stall_en = 0;

        plen[1].push_back(80);
        build();
        base = n_acc; n = 0;
        while (n_acc < base + 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(n < 200, "mid_body_wait", n, 200);
        @(posedge clk);
        #3;
        in_rst = 1'b1;
        rst = 1'b1;
        #1;
        ones = 0;
        for (int l = 0; l < NL; l++) ones += int'(lane_ready[l]);
        chk(out_valid == 0, "async_valid", out_valid, 0);
        chk(out_last == 0, "async_last", out_last, 0);
        chk(ones == 0, "async_ready", ones, 0);
        sb.delete();
        for (int l = 0; l < NL; l++) begin
            lane_q[l].delete();
            lane_hdr[l].delete();
            plen[l].delete();
        end
        m_ptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_rst = 1'b0;
        @(posedge clk);
        plen[3].push_back(8);
        plen[0].push_back(8);
        build(); drain(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
